fc_vector_loader: RTL and testbench
===================================

Name: fc_vector_loader

Overview:
- Sequential front/back end for the combinational fully-connected neuron layer.
- Accepts a serial stream of WIDTH-bit activations over valid/ready and assembles them into the IN-element parallel vector the layer consumes.
- Holds that vector stable while the combinational path settles, then captures the layer's ReLU result and returns it over a valid/ready output channel.
- Sits between the activation-stream fabric and each FC neuron instance.

Parameters:
- WIDTH, 8, activation bit width; layer coefficient width is matched to it.
- IN, 128, number of elements per vector (frame length).
- SETTLE_CYC, 2, cycles the vector is held before z is sampled; legal range 1..15.
- OUT_WIDTH, 8, saturated output width; used only with FC_OUT_SAT_EN.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- s_valid  in  1  input beat valid.
- s_ready  out  1  loader accepts a beat this cycle.
- s_data  in  WIDTH  activation value.
- s_last  in  1  final beat of the frame.
- x_vec  out  WIDTH x [0:IN-1]  unpacked array driven to the layer's x input.
- z_in  in  ZW  layer result; ZW = 2*WIDTH + $clog2(IN), which is 23 at the defaults.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream accepts the result.
- m_data  out  ZW, or OUT_WIDTH with FC_OUT_SAT_EN  captured result.
- err_len  out  1  sticky frame-length error.

Behaviour:
- Reset (async, rst_n=0):
  - state=FILL, idx=0.
  - All x_vec elements 0, m_valid=0, m_data=0, err_len=0.
  - s_ready=1 once reset is released.
- FILL:
  - s_ready=1.
  - On s_valid&&s_ready: x_vec[idx] <= s_data and idx increments.
  - Frame ends on whichever comes first: s_last=1, or the beat with idx==IN-1.
  - At frame end: idx clears, settle counter loads SETTLE_CYC-1, state goes to SETTLE.
- Length errors:
  - s_last on a beat with idx<IN-1: unwritten elements keep 0 (zero-padded), err_len<=1.
  - Beat with idx==IN-1 and s_last=0: frame still ends, err_len<=1.
  - In that case the next beat, whatever its s_last, belongs to the next frame.
- SETTLE:
  - s_ready=0; x_vec held constant.
  - Counter decrements each cycle.
  - On the cycle the counter reads 0: m_data <= z_in, m_valid <= 1, state goes to OUT.
- OUT:
  - s_ready=0; m_valid=1; m_data and x_vec held stable.
  - On m_valid&&m_ready: m_valid<=0, all x_vec elements clear to 0 in the same edge, state goes to FILL.
  - m_ready asserted earlier than m_valid has no effect.
- Latency:
  - The final beat is accepted at edge t.
  - m_valid rises at edge t+SETTLE_CYC.
  - The earliest next-frame beat is accepted at the edge after the output handshake edge.
  - There is no overlap of frames (single buffer).
- err_len is sticky; it clears only on reset.
- No combinational path from s_valid or m_ready to any output; s_ready is decoded from state only.
- Reset asserted mid-frame or mid-OUT: immediate return to reset values; the partial frame is discarded.

Optional Feature:
- Macro: FC_OUT_SAT_EN.
- Defined:
  - m_data is OUT_WIDTH bits.
  - Captured value = z_in clamped to 2^OUT_WIDTH-1. z_in is non-negative because it comes after ReLU.
  - Any bits of z_in above OUT_WIDTH-1 being set forces all ones.
  - An extra output port sat_flag (1 bit) is registered with m_data: 1 when clamping occurred.
- Undefined:
  - m_data is the full ZW bits, unmodified.
  - No sat_flag port.
  - OUT_WIDTH is unused.

Decomposition:
- Package fc_pkg:
  - state enum {FILL, SETTLE, OUT}.
  - Function zw(width, in) returning 2*width + $clog2(in).
  - Localparam for the settle counter width (4 bits).
- One natural sub-module: fc_out_sat, the combinational clamp, instantiated only under FC_OUT_SAT_EN.
- The index counter and state machine stay in the top module.

Test Plan:
- Full frame: 128 beats of value 1, s_last on beat 127; layer stub z_in = sum.
  - Required: m_valid exactly SETTLE_CYC cycles after the last beat; m_data=128; err_len=0.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid.
  - Required: m_data, m_valid and x_vec stable; s_ready=0 throughout; handshake on cycle 11; s_ready=1 next cycle.
- Short frame: s_last on beat 4 (idx=4) with data 5,6,7,8,9.
  - Required: x_vec[0:4]=5..9, x_vec[5:127]=0, err_len=1, result produced.
- Long stream: 130 beats with no s_last.
  - Required: first frame closes at beat 128; err_len=1; beats 129 and 130 become x_vec[0] and x_vec[1] of frame 2.
- Reset mid-fill: assert rst_n=0 after 50 beats.
  - Required: outputs zero asynchronously; after release, a fresh 128-beat frame yields the correct result.
- FC_OUT_SAT_EN, OUT_WIDTH=8:
  - z_in=300 -> m_data=255, sat_flag=1.
  - z_in=200 -> m_data=200, sat_flag=0.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared types and helpers for the fully-connected layer vector loader.
package fc_pkg;

    // Loader phases: collect a frame, let the layer settle, present the result.
    typedef enum logic [1:0] {
        FILL   = 2'd0,
        SETTLE = 2'd1,
        OUT    = 2'd2
    } state_t;

    // Width of the settle-down counter; holds SETTLE_CYC-1 for SETTLE_CYC up to 15.
    localparam int CNT_W = 4;

    // Width of the layer result: the product width plus growth for summing `in` terms.
    function automatic int zw(input int width, input int in);
        return 2 * width + $clog2(in);
    endfunction

endpackage

// File: rtl/fc_out_sat.sv
// Combinational clamp of the non-negative layer result to an OUT_W-bit unsigned value.
// Used by fc_vector_loader only when FC_OUT_SAT_EN is defined.
module fc_out_sat #(
    parameter int IN_W  = 23,
    parameter int OUT_W = 8
) (
    input  logic [IN_W-1:0]  z,
    output logic [OUT_W-1:0] y,
    output logic             sat
);

    // The input follows a ReLU, so any set bit above the output range means overflow.
    function automatic logic overflow(input logic [IN_W-1:0] v);
        return (v >> OUT_W) != '0;
    endfunction

    // Saturate to all ones on overflow, otherwise pass the low bits through.
    function automatic logic [OUT_W-1:0] clamp(input logic [IN_W-1:0] v);
        if (overflow(v)) begin
            return '1;
        end
        return OUT_W'(v);
    endfunction

    assign y   = clamp(z);
    assign sat = overflow(z);

endmodule

// File: rtl/fc_vector_loader.sv
// Serial-to-parallel front end and result capture for one combinational FC neuron.
// Activations arrive one per valid/ready beat and are assembled into x_vec; the
// vector is held while the layer settles, then z_in is captured and returned on
// the m_* channel. Single buffered: a new frame starts only after the result is taken.
// Optional build macro FC_OUT_SAT_EN: clamps the result to OUT_WIDTH bits and adds sat_flag.
module fc_vector_loader
    import fc_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int IN         = 128,
    parameter int SETTLE_CYC = 2,
    parameter int OUT_WIDTH  = 8,
    localparam int ZW        = zw(WIDTH, IN),
`ifdef FC_OUT_SAT_EN
    localparam int MW        = OUT_WIDTH
`else
    localparam int MW        = ZW
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x_vec [0:IN-1],
    input  logic [ZW-1:0]    z_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [MW-1:0]    m_data,
`ifdef FC_OUT_SAT_EN
    output logic             sat_flag,
`endif
    output logic             err_len
);

    localparam int               IDX_W       = $clog2(IN);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(IN - 1);
    localparam logic [CNT_W-1:0] SETTLE_INIT = CNT_W'(SETTLE_CYC - 1);

    // Reject configurations the counters cannot represent.
    if (SETTLE_CYC < 1 || SETTLE_CYC > 15) begin : g_bad_settle
        $error("SETTLE_CYC must be in 1..15");
    end
    if (IN < 2) begin : g_bad_in
        $error("IN must be at least 2");
    end

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] cnt;
    logic             accept;
    logic             frame_end;
    logic             capture;
    logic             take_out;
    logic [MW-1:0]    result;
`ifdef FC_OUT_SAT_EN
    logic             result_sat;
`endif

    // Ready depends on the registered state alone, so no input reaches it combinationally.
    assign s_ready   = (state == FILL);
    assign accept    = s_valid && s_ready;
    // A frame closes on s_last or when the vector is full, whichever comes first.
    assign frame_end = accept && (s_last || (idx == LAST_IDX));
    assign capture   = (state == SETTLE) && (cnt == '0);
    assign take_out  = (state == OUT) && m_valid && m_ready;

`ifdef FC_OUT_SAT_EN
    fc_out_sat #(
        .IN_W  (ZW),
        .OUT_W (OUT_WIDTH)
    ) u_out_sat (
        .z   (z_in),
        .y   (result),
        .sat (result_sat)
    );
`else
    assign result = z_in;
    if (OUT_WIDTH < 1) begin : g_bad_out_width
        $error("OUT_WIDTH must be positive");
    end
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: fill until frame end, settle until the counter expires, wait for the handshake.
    always_comb begin
        state_next = state;
        unique case (state)
            FILL:    if (frame_end) state_next = SETTLE;
            SETTLE:  if (cnt == '0) state_next = OUT;
            OUT:     if (take_out)  state_next = FILL;
            default: state_next = FILL;
        endcase
    end

    // Element index within the current frame and the settle-down counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            cnt <= '0;
        end else begin
            if (frame_end) begin
                idx <= '0;
                cnt <= SETTLE_INIT;
            end else if (accept) begin
                idx <= idx + 1'b1;
            end else if ((state == SETTLE) && (cnt != '0)) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    // Vector register: written beat by beat, cleared once the result is taken so short frames zero-pad.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) begin
                x_vec[i] <= '0;
            end
        end else if (accept) begin
            x_vec[idx] <= s_data;
        end else if (take_out) begin
            for (int i = 0; i < IN; i++) begin
                x_vec[i] <= '0;
            end
        end
    end

    // Sticky length error: s_last early, or the vector filled without s_last.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_len <= 1'b0;
        end else if (accept && (s_last != (idx == LAST_IDX))) begin
            err_len <= 1'b1;
        end
    end

    // Result capture at the end of the settle window; valid drops on the output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid  <= 1'b0;
            m_data   <= '0;
`ifdef FC_OUT_SAT_EN
            sat_flag <= 1'b0;
`endif
        end else if (capture) begin
            m_valid  <= 1'b1;
            m_data   <= result;
`ifdef FC_OUT_SAT_EN
            sat_flag <= result_sat;
`endif
        end else if (take_out) begin
            m_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fc_vector_loader.sv
// Self-checking bench for fc_vector_loader with a summing layer stub on z_in.
// The reference model splits the beat stream into frames with a queue and
// predicts the vector, the result and the sticky length error.
`timescale 1ns/1ps
module tb_fc_vector_loader;

    localparam int WIDTH      = 8;
    localparam int IN         = 128;
    localparam int SETTLE_CYC = 2;
    localparam int OUT_WIDTH  = 8;
    localparam int ZW         = 2 * WIDTH + $clog2(IN);
`ifdef FC_OUT_SAT_EN
    localparam int MW = OUT_WIDTH;
`else
    localparam int MW = ZW;
`endif

    logic             clk = 1'b0;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] x_vec [0:IN-1];
    logic [ZW-1:0]    z_in;
    logic             m_valid;
    logic             m_ready;
    logic [MW-1:0]    m_data;
    logic             err_len;
`ifdef FC_OUT_SAT_EN
    logic             sat_flag;
`endif

    int checks = 0;
    int errors = 0;

    fc_vector_loader #(
        .WIDTH      (WIDTH),
        .IN         (IN),
        .SETTLE_CYC (SETTLE_CYC),
        .OUT_WIDTH  (OUT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .x_vec    (x_vec),
        .z_in     (z_in),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
`ifdef FC_OUT_SAT_EN
        .sat_flag (sat_flag),
`endif
        .err_len  (err_len)
    );

    always #5 clk = ~clk;

    // Layer stub: unit weights, so z is the plain sum of the vector.
    always_comb begin
        z_in = '0;
        for (int i = 0; i < IN; i++) z_in = z_in + ZW'(x_vec[i]);
    end

    // ---------------- reference model ----------------
    logic [WIDTH-1:0] cur[$];
    logic [WIDTH-1:0] exp_vec [IN];
    bit               exp_err;

    task automatic model_clear_vec();
        for (int i = 0; i < IN; i++) exp_vec[i] = '0;
    endtask

    task automatic model_reset();
        cur.delete();
        exp_err = 1'b0;
        model_clear_vec();
    endtask

    task automatic model_beat(input logic [WIDTH-1:0] d, input bit last);
        cur.push_back(d);
        if (last || cur.size() == IN) begin
            if (!last || cur.size() != IN) exp_err = 1'b1;
            for (int i = 0; i < IN; i++) exp_vec[i] = (i < cur.size()) ? cur[i] : '0;
            cur.delete();
        end
    endtask

    function automatic longint model_sum();
        longint s = 0;
        for (int i = 0; i < IN; i++) s += exp_vec[i];
        return s;
    endfunction

    function automatic logic [MW-1:0] exp_md();
        longint s = model_sum();
`ifdef FC_OUT_SAT_EN
        if (s > (64'd1 << OUT_WIDTH) - 1) s = (64'd1 << OUT_WIDTH) - 1;
`endif
        return MW'(s);
    endfunction

    function automatic int vec_diff();
        int n = 0;
        for (int i = 0; i < IN; i++) if (x_vec[i] !== exp_vec[i]) n++;
        return n;
    endfunction

    // ---------------- drivers ----------------
    task automatic beat(input logic [WIDTH-1:0] d, input bit last, input int gap);
        int budget = 0;
        s_valid = 1'b0;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        while (s_ready !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        if (s_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL s_ready_timeout got %b want 1", s_ready);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        model_beat(d, last);
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (m_valid !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        if (m_valid !== 1'b1) begin
            checks++; errors++;
            $display("FAIL result_timeout m_valid got %b want 1", m_valid);
        end
    endtask

    task automatic handshake();
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        model_clear_vec();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; m_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL reset_m_data got %0d want 0", m_data); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL reset_err_len got %b want 0", err_len); end
        checks++; if (vec_diff() != 0) begin errors++; $display("FAIL reset_x_vec got %0d nonzero want 0", vec_diff()); end
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
    endtask

    task automatic test_full_frame();
        int cyc;
        for (int i = 0; i < IN; i++) beat(8'd1, i == IN - 1, 0);
        wait_result(cyc);
        checks++; if (cyc != SETTLE_CYC) begin errors++; $display("FAIL full_latency got %0d want %0d", cyc, SETTLE_CYC); end
        checks++; if (m_data !== MW'(128)) begin errors++; $display("FAIL full_m_data got %0d want 128", m_data); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL full_err_len got %b want 0", err_len); end
        checks++; if (vec_diff() != 0) begin errors++; $display("FAIL full_x_vec got %0d diffs want 0", vec_diff()); end
        handshake();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL full_m_valid_drop got %b want 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL full_s_ready_back got %b want 1", s_ready); end
        checks++; if (vec_diff() != 0) begin errors++; $display("FAIL full_x_vec_clear got %0d diffs want 0", vec_diff()); end
    endtask

    task automatic test_backpressure();
        int cyc;
        logic [MW-1:0] want;
        for (int i = 0; i < IN; i++) beat(WIDTH'($urandom_range(0, 255)), i == IN - 1, $urandom_range(0, 2));
        wait_result(cyc);
        want = exp_md();
        for (int c = 0; c < 10; c++) begin
            checks++; if (m_valid !== 1'b1) begin errors++; $display("FAIL bp_m_valid c%0d got %b want 1", c, m_valid); end
            checks++; if (m_data !== want) begin errors++; $display("FAIL bp_m_data c%0d got %0d want %0d", c, m_data, want); end
            checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_s_ready c%0d got %b want 0", c, s_ready); end
            checks++; if (vec_diff() != 0) begin errors++; $display("FAIL bp_x_vec c%0d got %0d diffs want 0", c, vec_diff()); end
            @(negedge clk);
        end
        handshake();
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL bp_m_valid_drop got %b want 0", m_valid); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_s_ready_back got %b want 1", s_ready); end
    endtask

    task automatic test_short_frame();
        int cyc;
        for (int i = 0; i < 5; i++) beat(WIDTH'(5 + i), i == 4, 0);
        wait_result(cyc);
        checks++; if (vec_diff() != 0) begin errors++; $display("FAIL short_x_vec got %0d diffs want 0", vec_diff()); end
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL short_err_len got %b want 1", err_len); end
        checks++; if (m_data !== MW'(35)) begin errors++; $display("FAIL short_m_data got %0d want 35", m_data); end
        handshake();
    endtask

    task automatic test_long_stream();
        int cyc;
        logic [WIDTH-1:0] d129, d130, d131;
        for (int i = 0; i < IN; i++) beat(WIDTH'($urandom_range(0, 255)), 1'b0, 0);
        wait_result(cyc);
        checks++; if (err_len !== 1'b1) begin errors++; $display("FAIL long_err_len got %b want 1", err_len); end
        checks++; if (m_data !== exp_md()) begin errors++; $display("FAIL long_m_data got %0d want %0d", m_data, exp_md()); end
        checks++; if (cyc != SETTLE_CYC) begin errors++; $display("FAIL long_latency got %0d want %0d", cyc, SETTLE_CYC); end
        handshake();
        d129 = WIDTH'($urandom_range(1, 255));
        d130 = WIDTH'($urandom_range(1, 255));
        beat(d129, 1'b0, 0);
        beat(d130, 1'b0, 0);
        checks++; if (x_vec[0] !== d129) begin errors++; $display("FAIL long_next_x0 got %0d want %0d", x_vec[0], d129); end
        checks++; if (x_vec[1] !== d130) begin errors++; $display("FAIL long_next_x1 got %0d want %0d", x_vec[1], d130); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL long_still_fill got %b want 1", s_ready); end
        d131 = WIDTH'($urandom_range(0, 255));
        beat(d131, 1'b1, 0);
        wait_result(cyc);
        checks++; if (m_data !== exp_md()) begin errors++; $display("FAIL long_frame2_m_data got %0d want %0d", m_data, exp_md()); end
        checks++; if (vec_diff() != 0) begin errors++; $display("FAIL long_frame2_x_vec got %0d diffs want 0", vec_diff()); end
        handshake();
    endtask

    task automatic test_random();
        int cyc;
        int len;
        bit early;
        for (int f = 0; f < 8; f++) begin
            len   = (f % 3 == 0) ? IN : $urandom_range(1, IN);
            early = $urandom_range(0, 1);
            m_ready = early;
            for (int i = 0; i < len; i++) beat(WIDTH'($urandom_range(0, 255)), i == len - 1, $urandom_range(0, 1));
            wait_result(cyc);
            checks++; if (cyc != SETTLE_CYC) begin errors++; $display("FAIL rnd_latency f%0d got %0d want %0d", f, cyc, SETTLE_CYC); end
            checks++; if (m_data !== exp_md()) begin errors++; $display("FAIL rnd_m_data f%0d got %0d want %0d", f, m_data, exp_md()); end
            checks++; if (err_len !== exp_err) begin errors++; $display("FAIL rnd_err_len f%0d got %b want %b", f, err_len, exp_err); end
            checks++; if (vec_diff() != 0) begin errors++; $display("FAIL rnd_x_vec f%0d got %0d diffs want 0", f, vec_diff()); end
            if (!early) repeat ($urandom_range(0, 3)) @(negedge clk);
            handshake();
            checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rnd_m_valid_drop f%0d got %b want 0", f, m_valid); end
            checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rnd_s_ready f%0d got %b want 1", f, s_ready); end
        end
    endtask

    task automatic test_reset_mid_fill();
        int cyc;
        for (int i = 0; i < 50; i++) beat(WIDTH'($urandom_range(1, 255)), 1'b0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL midrst_m_valid got %b want 0", m_valid); end
        checks++; if (m_data !== '0) begin errors++; $display("FAIL midrst_m_data got %0d want 0", m_data); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL midrst_err_len got %b want 0", err_len); end
        checks++; if (vec_diff() != 0) begin errors++; $display("FAIL midrst_x_vec got %0d nonzero want 0", vec_diff()); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < IN; i++) beat(WIDTH'($urandom_range(0, 255)), i == IN - 1, 0);
        wait_result(cyc);
        checks++; if (m_data !== exp_md()) begin errors++; $display("FAIL midrst_frame_m_data got %0d want %0d", m_data, exp_md()); end
        checks++; if (err_len !== 1'b0) begin errors++; $display("FAIL midrst_frame_err got %b want 0", err_len); end
        checks++; if (vec_diff() != 0) begin errors++; $display("FAIL midrst_frame_x_vec got %0d diffs want 0", vec_diff()); end
        handshake();
    endtask

`ifdef FC_OUT_SAT_EN
    task automatic test_saturation();
        int cyc;
        beat(8'd255, 1'b0, 0);
        beat(8'd45, 1'b1, 0);
        wait_result(cyc);
        checks++; if (m_data !== MW'(255)) begin errors++; $display("FAIL sat_hi_m_data got %0d want 255", m_data); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_hi_flag got %b want 1", sat_flag); end
        handshake();
        beat(8'd100, 1'b0, 0);
        beat(8'd100, 1'b1, 0);
        wait_result(cyc);
        checks++; if (m_data !== MW'(200)) begin errors++; $display("FAIL sat_lo_m_data got %0d want 200", m_data); end
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_lo_flag got %b want 0", sat_flag); end
        handshake();
    endtask
`endif

    initial begin
        test_reset();
        test_full_frame();
        test_backpressure();
        test_short_frame();
        test_long_stream();
        test_random();
        test_reset_mid_fill();
`ifdef FC_OUT_SAT_EN
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
